// File: rtl/i2c_req_arbiter_if.sv
// Purpose: bundles the requester-side and I2C-master-side signals of the
//          request arbiter into one interface.
// Ports:   master modport = arbiter view (drives gnt/rsp_*/m_* commands);
//          slave modport  = requesters plus I2C master (drive req_*, m_dout/busy/ackErr/done).
interface i2c_req_arbiter_if #(
  parameter int N_REQ = 4
) ();
  // requester side
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_rw;
  logic [7*N_REQ-1:0] req_addr;
  logic [8*N_REQ-1:0] req_din;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   rsp_valid;
  logic [7:0]         rsp_data;
  logic               rsp_err;
  logic               rsp_timeout;
  // I2C master side
  logic               m_rw;
  logic               m_dataValid;
  logic [6:0]         m_addr;
  logic [7:0]         m_din;
  logic [7:0]         m_dout;
  logic               m_busy;
  logic               m_ackErr;
  logic               m_done;

  modport master (
    input  req, req_rw, req_addr, req_din,
    input  m_dout, m_busy, m_ackErr, m_done,
    output gnt, rsp_valid, rsp_data, rsp_err, rsp_timeout,
    output m_rw, m_dataValid, m_addr, m_din
  );

  modport slave (
    output req, req_rw, req_addr, req_din,
    output m_dout, m_busy, m_ackErr, m_done,
    input  gnt, rsp_valid, rsp_data, rsp_err, rsp_timeout,
    input  m_rw, m_dataValid, m_addr, m_din
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Purpose: round-robin sharing of one I2C master between N_REQ requesters,
//          with command latching, handshake sequencing and a done watchdog.
// Ports:   clk, rst (async, active-high); bus = i2c_req_arbiter_if.master
//          carrying req/req_rw/req_addr/req_din, gnt, rsp_*, and m_* to/from the master.
// Latency: grant and m_* one cycle after req seen in IDLE; rsp_valid one cycle
//          after m_done (or watchdog expiry); at least one idle cycle between grants.
module i2c_req_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input logic               clk,
  input logic               rst,
  i2c_req_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic             found;
  int               scan_idx;
  logic [CNT_W-1:0] cnt;
  logic             timed_out;
  logic             do_grant, do_done, do_timeout, do_release;

  // Round-robin pick: first set request scanning upward from ptr+1, wrapping.
  always_comb begin
    found    = 1'b0;
    win      = ptr;
    scan_idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = (int'(ptr) + k) % N_REQ;
      if (!found && bus.req[scan_idx]) begin
        found = 1'b1;
        win   = PTR_W'(scan_idx);
      end
    end
  end

  assign timed_out = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    do_release = 1'b0;
    case (state)
      IDLE: begin
        // m_busy gate also covers a master still running after a watchdog abort
        if (found && !bus.m_busy) begin
          do_grant  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (timed_out) begin
          do_timeout = 1'b1;
          state_nxt  = RESP;
        end else if (bus.m_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // done beats a coincident watchdog expiry
        if (bus.m_done) begin
          do_done   = 1'b1;
          state_nxt = RESP;
        end else if (timed_out) begin
          do_timeout = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        do_release = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr             <= PTR_W'(N_REQ - 1);
      cnt             <= '0;
      bus.gnt         <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_data    <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.m_rw        <= 1'b0;
      bus.m_dataValid <= 1'b0;
      bus.m_addr      <= '0;
      bus.m_din       <= '0;
    end else begin
      if (do_grant) begin
        bus.gnt         <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
        ptr             <= win;
        cnt             <= '0;
        bus.m_rw        <= bus.req_rw[win];
        bus.m_addr      <= bus.req_addr[7*win +: 7];
        bus.m_din       <= bus.req_din[8*win +: 8];
        bus.m_dataValid <= 1'b1;
      end
      if (state == ISSUE || state == WAIT_DONE) begin
        cnt <= cnt + 1'b1;
      end
      if (do_done) begin
        bus.rsp_valid   <= bus.gnt;
        bus.rsp_data    <= bus.m_rw ? bus.m_dout : 8'h00;
        bus.rsp_err     <= bus.m_ackErr;
        bus.rsp_timeout <= 1'b0;
      end
      if (do_timeout) begin
        bus.rsp_valid   <= bus.gnt;
        bus.rsp_data    <= 8'h00;
        bus.rsp_err     <= 1'b1;
        bus.rsp_timeout <= 1'b1;
      end
      if (do_release) begin
        bus.rsp_valid   <= '0;
        bus.rsp_data    <= '0;
        bus.rsp_err     <= 1'b0;
        bus.rsp_timeout <= 1'b0;
        bus.gnt         <= '0;
        bus.m_dataValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Purpose: directed self-checking bench for i2c_req_arbiter with a simple
//          behavioural I2C master model (busy, done after N cycles, hang option).
// Ports:   none; drives clk/rst and an i2c_req_arbiter_if instance.
module tb_i2c_req_arbiter;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic clk;
  logic rst;

  i2c_req_arbiter_if #(.N_REQ(N)) ifc ();

  i2c_req_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // master model controls
  int         model_bits;
  logic [7:0] model_dout;
  logic       model_ack;
  logic       model_hang;
  logic       release_req;
  int         ms;
  int         mcnt;

  // scratch for the main sequence
  logic [N-1:0] g;
  logic [N-1:0] v;
  bit           ok;
  int           cyc;

  // I2C master model: busy one cycle after dataValid, done pulse model_bits later
  initial begin
    ms = 0; mcnt = 0;
    ifc.m_busy = 1'b0; ifc.m_done = 1'b0; ifc.m_dout = 8'h00; ifc.m_ackErr = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ms = 0; mcnt = 0;
        ifc.m_busy = 1'b0; ifc.m_done = 1'b0; ifc.m_ackErr = 1'b0;
      end else begin
        ifc.m_done = 1'b0;
        case (ms)
          0: if (ifc.m_dataValid && !ifc.m_busy) ms = 1;
          1: begin ifc.m_busy = 1'b1; mcnt = 0; ms = 2; end
          2: begin
            if (release_req) begin
              release_req = 1'b0;
              ifc.m_busy = 1'b0;
              ms = 0;
            end else begin
              mcnt++;
              if (!model_hang && mcnt == model_bits) begin
                ifc.m_done = 1'b1; ifc.m_busy = 1'b0;
                ifc.m_dout = model_dout; ifc.m_ackErr = model_ack;
                ms = 3;
              end
            end
          end
          default: if (!ifc.m_dataValid) ms = 0;
        endcase
      end
    end
  end

  task automatic set_cmd(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
    ifc.req_rw[i]        = rw;
    ifc.req_addr[7*i +: 7] = a;
    ifc.req_din[8*i +: 8]  = d;
  endtask

  task automatic wait_gnt(output logic [N-1:0] gg, output bit okk);
    okk = 1'b0; gg = '0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (ifc.gnt != '0) begin gg = ifc.gnt; okk = 1'b1; break; end
    end
  endtask

  task automatic wait_rsp(output logic [N-1:0] vv, output int cc, output bit okk);
    okk = 1'b0; vv = '0; cc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (ifc.rsp_valid != '0) begin vv = ifc.rsp_valid; cc = i; okk = 1'b1; break; end
    end
  endtask

  task test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ifc.gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", ifc.gnt); end
    n_cmp++; if (ifc.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0000", ifc.rsp_valid); end
    n_cmp++; if (ifc.m_dataValid !== 1'b0) begin n_bad++; $display("FAIL reset_dataValid: got %b want 0", ifc.m_dataValid); end
    n_cmp++; if ({ifc.m_rw, ifc.m_addr, ifc.m_din} !== 16'h0000) begin n_bad++; $display("FAIL reset_m_cmd: got %h want 0000", {ifc.m_rw, ifc.m_addr, ifc.m_din}); end
    n_cmp++; if ({ifc.rsp_data, ifc.rsp_err, ifc.rsp_timeout} !== 10'h000) begin n_bad++; $display("FAIL reset_rsp_fields: got %h want 000", {ifc.rsp_data, ifc.rsp_err, ifc.rsp_timeout}); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ifc.gnt !== 4'b0000) begin n_bad++; $display("FAIL idle_no_req_gnt: got %b want 0000", ifc.gnt); end
  endtask

  task test_single_write;
    bit stable_bad;
    model_bits = 20;
    set_cmd(0, 1'b0, 7'h55, 8'h2F);
    ifc.req[0] = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ifc.gnt !== 4'b0001) begin n_bad++; $display("FAIL wr_gnt_latency: got %b want 0001", ifc.gnt); end
    n_cmp++; if (ifc.m_dataValid !== 1'b1) begin n_bad++; $display("FAIL wr_dataValid: got %b want 1", ifc.m_dataValid); end
    n_cmp++; if ({ifc.m_rw, ifc.m_addr, ifc.m_din} !== {1'b0, 7'h55, 8'h2F}) begin n_bad++; $display("FAIL wr_m_cmd: got %h want 552F", {ifc.m_rw, ifc.m_addr, ifc.m_din}); end
    stable_bad = 1'b0; ok = 1'b0; cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (ifc.rsp_valid != '0) begin cyc = i; ok = 1'b1; break; end
      if (ifc.m_addr !== 7'h55 || ifc.m_din !== 8'h2F || ifc.m_rw !== 1'b0 || ifc.m_dataValid !== 1'b1 || ifc.gnt !== 4'b0001) stable_bad = 1'b1;
    end
    n_cmp++; if (stable_bad !== 1'b0) begin n_bad++; $display("FAIL wr_cmd_stable: got unstable=%b want 0", stable_bad); end
    n_cmp++; if (ok !== 1'b1 || cyc != 22) begin n_bad++; $display("FAIL wr_rsp_latency: got seen=%b cycles=%0d want seen=1 cycles=22", ok, cyc); end
    n_cmp++; if (ifc.rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL wr_rsp_valid: got %b want 0001", ifc.rsp_valid); end
    n_cmp++; if ({ifc.rsp_err, ifc.rsp_timeout, ifc.rsp_data} !== 10'h000) begin n_bad++; $display("FAIL wr_rsp_fields: got %h want 000", {ifc.rsp_err, ifc.rsp_timeout, ifc.rsp_data}); end
    ifc.req[0] = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({ifc.gnt, ifc.rsp_valid, ifc.m_dataValid} !== 9'h000) begin n_bad++; $display("FAIL wr_release: got gnt=%b rsp_valid=%b dv=%b want all 0", ifc.gnt, ifc.rsp_valid, ifc.m_dataValid); end
  endtask

  task test_read;
    model_bits = 10; model_dout = 8'hA5;
    set_cmd(2, 1'b1, 7'h50, 8'h00);
    ifc.req[2] = 1'b1;
    wait_gnt(g, ok);
    n_cmp++; if (ok !== 1'b1 || g !== 4'b0100) begin n_bad++; $display("FAIL rd_gnt: got %b want 0100", g); end
    n_cmp++; if ({ifc.m_rw, ifc.m_addr} !== {1'b1, 7'h50}) begin n_bad++; $display("FAIL rd_m_cmd: got %h want d0", {ifc.m_rw, ifc.m_addr}); end
    wait_rsp(v, cyc, ok);
    n_cmp++; if (ok !== 1'b1 || v !== 4'b0100) begin n_bad++; $display("FAIL rd_rsp_valid: got %b want 0100", v); end
    n_cmp++; if (ifc.rsp_data !== 8'hA5) begin n_bad++; $display("FAIL rd_rsp_data: got %h want a5", ifc.rsp_data); end
    // ptr is now 2: with 1 and 3 both requesting, 3 must win
    ifc.req[2] = 1'b0;
    set_cmd(1, 1'b0, 7'h01, 8'h11);
    set_cmd(3, 1'b0, 7'h03, 8'h33);
    ifc.req[1] = 1'b1; ifc.req[3] = 1'b1;
    wait_gnt(g, ok);
    n_cmp++; if (ok !== 1'b1 || g !== 4'b1000) begin n_bad++; $display("FAIL rd_ptr_after_read: got %b want 1000", g); end
    wait_rsp(v, cyc, ok);
    ifc.req[3] = 1'b0;
    wait_gnt(g, ok);
    n_cmp++; if (ok !== 1'b1 || g !== 4'b0010) begin n_bad++; $display("FAIL rd_second_gnt: got %b want 0010", g); end
    wait_rsp(v, cyc, ok);
    ifc.req[1] = 1'b0;
  endtask

  task test_round_robin;
    logic [N-1:0] want;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_bits = 6; model_dout = 8'h00;
    for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 7'(8'h10 + i), 8'(8'hC0 + i));
    ifc.req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      want = 4'b0001 << k;
      wait_gnt(g, ok);
      n_cmp++; if (ok !== 1'b1 || g !== want) begin n_bad++; $display("FAIL rr_order_%0d: got %b want %b", k, g, want); end
      n_cmp++; if (ifc.m_addr !== 7'(8'h10 + k)) begin n_bad++; $display("FAIL rr_addr_%0d: got %h want %h", k, ifc.m_addr, 8'h10 + k); end
      wait_rsp(v, cyc, ok);
      n_cmp++; if (ok !== 1'b1 || v !== want) begin n_bad++; $display("FAIL rr_rsp_%0d: got %b want %b", k, v, want); end
      ifc.req[k] = 1'b0;
    end
    // move ptr to 1, then 3 must be served before 0
    ifc.req = 4'b0010;
    wait_gnt(g, ok);
    wait_rsp(v, cyc, ok);
    ifc.req = 4'b1001;
    wait_gnt(g, ok);
    n_cmp++; if (ok !== 1'b1 || g !== 4'b1000) begin n_bad++; $display("FAIL rr_wrap_first: got %b want 1000", g); end
    wait_rsp(v, cyc, ok);
    ifc.req[3] = 1'b0;
    wait_gnt(g, ok);
    n_cmp++; if (ok !== 1'b1 || g !== 4'b0001) begin n_bad++; $display("FAIL rr_wrap_second: got %b want 0001", g); end
    wait_rsp(v, cyc, ok);
    ifc.req[0] = 1'b0;
  endtask

  task test_nack;
    model_bits = 8; model_ack = 1'b1;
    set_cmd(1, 1'b0, 7'h2A, 8'h77);
    ifc.req[1] = 1'b1;
    wait_gnt(g, ok);
    wait_rsp(v, cyc, ok);
    n_cmp++; if (ok !== 1'b1 || v !== 4'b0010) begin n_bad++; $display("FAIL nack_rsp_valid: got %b want 0010", v); end
    n_cmp++; if ({ifc.rsp_err, ifc.rsp_timeout} !== 2'b10) begin n_bad++; $display("FAIL nack_err_tmo: got %b want 10", {ifc.rsp_err, ifc.rsp_timeout}); end
    ifc.req[1] = 1'b0;
    model_ack = 1'b0;
  endtask

  task test_timeout;
    bit gap_bad;
    model_hang = 1'b1; model_dout = 8'hEE;
    set_cmd(3, 1'b1, 7'h11, 8'h00);
    ifc.req[3] = 1'b1;
    wait_gnt(g, ok);
    n_cmp++; if (ok !== 1'b1 || g !== 4'b1000) begin n_bad++; $display("FAIL tmo_gnt: got %b want 1000", g); end
    wait_rsp(v, cyc, ok);
    n_cmp++; if (ok !== 1'b1 || v !== 4'b1000 || cyc != TMO) begin n_bad++; $display("FAIL tmo_latency: got valid=%b cycles=%0d want 1000 cycles=%0d", v, cyc, TMO); end
    n_cmp++; if ({ifc.rsp_timeout, ifc.rsp_err, ifc.rsp_data} !== {1'b1, 1'b1, 8'h00}) begin n_bad++; $display("FAIL tmo_fields: got %h want 300", {ifc.rsp_timeout, ifc.rsp_err, ifc.rsp_data}); end
    ifc.req[3] = 1'b0;
    set_cmd(0, 1'b0, 7'h22, 8'h5A);
    ifc.req[0] = 1'b1;
    gap_bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ifc.gnt !== 4'b0000 || ifc.m_dataValid !== 1'b0) gap_bad = 1'b1;
    end
    n_cmp++; if (gap_bad !== 1'b0) begin n_bad++; $display("FAIL tmo_no_gnt_while_busy: got granted=%b want 0", gap_bad); end
    model_hang = 1'b0; model_bits = 5;
    release_req = 1'b1;
    wait_gnt(g, ok);
    n_cmp++; if (ok !== 1'b1 || g !== 4'b0001) begin n_bad++; $display("FAIL tmo_gnt_after_idle: got %b want 0001", g); end
    wait_rsp(v, cyc, ok);
    n_cmp++; if (ok !== 1'b1 || v !== 4'b0001 || ifc.rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_next_txn: got valid=%b tmo=%b want 0001 0", v, ifc.rsp_timeout); end
    ifc.req[0] = 1'b0;
  endtask

  task test_async_reset;
    bit spurious;
    model_bits = 30;
    set_cmd(1, 1'b0, 7'h0B, 8'h01);
    set_cmd(2, 1'b0, 7'h0C, 8'h02);
    ifc.req[1] = 1'b1;
    wait_gnt(g, ok);
    n_cmp++; if (ok !== 1'b1 || g !== 4'b0010) begin n_bad++; $display("FAIL ar_first_gnt: got %b want 0010", g); end
    ifc.req[2] = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if ({ifc.gnt, ifc.rsp_valid, ifc.m_dataValid} !== 9'h000) begin n_bad++; $display("FAIL ar_immediate: got gnt=%b rsp_valid=%b dv=%b want all 0", ifc.gnt, ifc.rsp_valid, ifc.m_dataValid); end
    n_cmp++; if ({ifc.m_addr, ifc.m_din} !== 15'h0000) begin n_bad++; $display("FAIL ar_m_cmd: got %h want 0000", {ifc.m_addr, ifc.m_din}); end
    spurious = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ifc.rsp_valid !== 4'b0000) spurious = 1'b1;
    end
    rst = 1'b0;
    wait_gnt(g, ok);
    n_cmp++; if (ok !== 1'b1 || g !== 4'b0010) begin n_bad++; $display("FAIL ar_ptr_reset_gnt: got %b want 0010", g); end
    n_cmp++; if (spurious !== 1'b0) begin n_bad++; $display("FAIL ar_no_rsp_for_aborted: got spurious=%b want 0", spurious); end
    model_bits = 4;
    wait_rsp(v, cyc, ok);
    n_cmp++; if (ok !== 1'b1 || v !== 4'b0010) begin n_bad++; $display("FAIL ar_rsp1: got %b want 0010", v); end
    ifc.req[1] = 1'b0;
    wait_gnt(g, ok);
    n_cmp++; if (ok !== 1'b1 || g !== 4'b0100) begin n_bad++; $display("FAIL ar_gnt2: got %b want 0100", g); end
    wait_rsp(v, cyc, ok);
    ifc.req[2] = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    ifc.req = '0; ifc.req_rw = '0; ifc.req_addr = '0; ifc.req_din = '0;
    model_bits = 20; model_dout = 8'h00; model_ack = 1'b0; model_hang = 1'b0; release_req = 1'b0;
    test_reset;
    test_single_write;
    test_read;
    test_round_robin;
    test_nack;
    test_timeout;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit: got no completion want finish before 300000");
    $fatal(1);
  end

endmodule
